// File: rtl/ham_encode_stream.sv
// ham_encode_stream
// Streaming Hamming(15,11) encoder feeding the hamFix corrector. Data words
// arrive on a valid/ready handshake, are encoded and optionally corrupted
// with a single-bit error, buffered in a small FIFO and presented on a second
// valid/ready handshake. Free-running wrap-around counters track accepted
// words and injected errors.
//
// DEPTH must be a power of two in 2..16 so that the pointers wrap naturally.

module ham_encode_stream #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    // upstream data handshake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:1]      in_data,
    // per-word error injection
    input  logic             inj_en,
    input  logic [3:0]       inj_pos,
    // downstream codeword handshake
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:1]      out_ham,
    // statistics
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] inj_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Hamming(15,11) encoder: parity bits at the power-of-two positions,
    // data bits fill the remaining positions in ascending order.
    // ------------------------------------------------------------------
    function automatic logic [15:1] encode(input logic [11:1] d);
        logic p1, p2, p4, p8;
        p1 = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[9]  ^ d[11];
        p2 = d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[7] ^ d[10] ^ d[11];
        p4 = d[2] ^ d[3] ^ d[4] ^ d[8] ^ d[9] ^ d[10] ^ d[11];
        p8 = d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[11];
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:1]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W:0]   occ_q,      occ_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] inj_cnt_q,  inj_cnt_d;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic        push;
    logic        pop;
    logic        inj_hit;
    logic [15:1] inj_mask;
    logic [15:1] wr_word;

    // Readiness is a function of registered occupancy only, so there is
    // no combinational path from out_ready back to in_ready.
    assign in_ready  = (occ_q < FULL_OCC);
    assign out_valid = (occ_q != '0);

    // A word presented while reset is high must never land in the FIFO.
    assign push    = in_valid && in_ready && !reset;
    assign pop     = out_valid && out_ready;
    assign inj_hit = inj_en && (inj_pos != 4'd0);

    // Build the one-hot error mask for the selected codeword position.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        inj_mask = '0;
        if (inj_en) begin
            for (int i = 1; i <= 15; i++) begin
                if (inj_pos == 4'(i)) begin
                    inj_mask[i] = 1'b1;
                end
            end
        end
    end

    assign wr_word = encode(in_data) ^ inj_mask;

    // ------------------------------------------------------------------
    // Next-state logic for pointers, occupancy and counters
    // ------------------------------------------------------------------

    // Advance pointers and occupancy on push/pop; bump statistics on push.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        word_cnt_d = word_cnt_q;
        inj_cnt_d  = inj_cnt_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (inj_hit) begin
                inj_cnt_d = inj_cnt_q + CNT_W'(1);
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control state register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            word_cnt_q <= '0;
            inj_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            word_cnt_q <= word_cnt_d;
            inj_cnt_q  <= inj_cnt_d;
        end
    end

    // Codeword storage, written at the tail on every accepted word.
    always_ff @(posedge clock) begin
        // NOTE: the storage array is deliberately not reset; occupancy
        // gates every read, so stale entries are never observable.
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Head entry is shown only while the FIFO holds data; zero otherwise.
    assign out_ham    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign word_count = word_cnt_q;
    assign inj_count  = inj_cnt_q;

endmodule

// File: tb/tb_ham_encode_stream.sv
// Self-checking bench for ham_encode_stream: a table of hand-encoded
// vectors plus directed sequences for back-pressure, wrap-around and reset.

module tb_ham_encode_stream;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [11:1]      in_data;
    logic             inj_en;
    logic [3:0]       inj_pos;
    logic             out_valid;
    logic             out_ready;
    logic [15:1]      out_ham;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] inj_count;

    ham_encode_stream #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .inj_en     (inj_en),
        .inj_pos    (inj_pos),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ham    (out_ham),
        .word_count (word_count),
        .inj_count  (inj_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [11:1] data;
        logic        inj_en;
        logic [3:0]  inj_pos;
        logic [15:1] exp_ham;
        logic        exp_inj;
    } vec_t;

    vec_t        vecs [12];
    logic [15:1] basis [1:11];

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_words = '0;
    logic [CNT_W-1:0] exp_inj   = '0;

    // Linear reference: XOR of hand-derived codewords for each single data bit.
    function automatic logic [15:1] ref_encode(input logic [11:1] d);
        logic [15:1] r;
        r = '0;
        for (int i = 1; i <= 11; i++) begin
            if (d[i]) r = r ^ basis[i];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Single-bit codewords, derived by hand from the parity equations.
        basis[1]  = 15'h0007; basis[2]  = 15'h0019; basis[3]  = 15'h002A;
        basis[4]  = 15'h004B; basis[5]  = 15'h0181; basis[6]  = 15'h0282;
        basis[7]  = 15'h0483; basis[8]  = 15'h0888; basis[9]  = 15'h1089;
        basis[10] = 15'h208A; basis[11] = 15'h408B;

        //            data      inj  pos    expected   injected
        vecs[0]  = '{11'h001, 1'b0, 4'd0,  15'h0007, 1'b0};
        vecs[1]  = '{11'h000, 1'b0, 4'd0,  15'h0000, 1'b0};
        vecs[2]  = '{11'h7FF, 1'b0, 4'd0,  15'h7FFF, 1'b0};
        vecs[3]  = '{11'h000, 1'b1, 4'd5,  15'h0010, 1'b1};
        vecs[4]  = '{11'h000, 1'b1, 4'd0,  15'h0000, 1'b0};
        vecs[5]  = '{11'h000, 1'b0, 4'd3,  15'h0000, 1'b0};
        vecs[6]  = '{11'h7FF, 1'b1, 4'd15, 15'h3FFF, 1'b1};
        vecs[7]  = '{11'h7FF, 1'b1, 4'd1,  15'h7FFE, 1'b1};
        vecs[8]  = '{11'h002, 1'b0, 4'd0,  15'h0019, 1'b0};
        vecs[9]  = '{11'h400, 1'b0, 4'd0,  15'h408B, 1'b0};
        vecs[10] = '{11'h010, 1'b0, 4'd0,  15'h0181, 1'b0};
        vecs[11] = '{11'h555, 1'b1, 4'd8,  15'h55AD, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        inj_en    = 1'b0;
        inj_pos   = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst out_valid",  32'(out_valid),  32'd0);
        check("rst in_ready",   32'(in_ready),   32'd1);
        check("rst out_ham",    32'(out_ham),    32'd0);
        check("rst word_count", 32'(word_count), 32'd0);
        check("rst inj_count",  32'(inj_count),  32'd0);
        reset = 1'b0;

        // Table vectors: push every cycle with out_ready high, so the head is
        // always the word accepted at the most recent edge.
        out_ready = 1'b1;
        for (int v = 0; v < 12; v++) begin
            in_valid = 1'b1;
            in_data  = vecs[v].data;
            inj_en   = vecs[v].inj_en;
            inj_pos  = vecs[v].inj_pos;
            tick();
            exp_words = exp_words + 1'b1;
            if (vecs[v].exp_inj) exp_inj = exp_inj + 1'b1;
            check($sformatf("vec%0d out_valid", v),  32'(out_valid),  32'd1);
            check($sformatf("vec%0d out_ham", v),    32'(out_ham),    32'(vecs[v].exp_ham));
            check($sformatf("vec%0d word_count", v), 32'(word_count), 32'(exp_words));
            check($sformatf("vec%0d inj_count", v),  32'(inj_count),  32'(exp_inj));
            check($sformatf("vec%0d in_ready", v),   32'(in_ready),   32'd1);
        end

        // Idle cycle with junk on the side inputs: nothing may change.
        in_valid = 1'b0;
        in_data  = 11'h7FF;
        inj_en   = 1'b1;
        inj_pos  = 4'd7;
        tick();
        check("idle out_valid",  32'(out_valid),  32'd0);
        check("idle out_ham",    32'(out_ham),    32'd0);
        check("idle word_count", 32'(word_count), 32'(exp_words));
        check("idle inj_count",  32'(inj_count),  32'(exp_inj));
        inj_en  = 1'b0;
        inj_pos = '0;

        // Back-pressure: fill the FIFO with out_ready low.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 11'(i + 1);
            tick();
            exp_words = exp_words + 1'b1;
            check($sformatf("fill%0d in_ready", i), 32'(in_ready), 32'(i + 1 < DEPTH));
        end
        in_data = 11'h7FF;
        tick();
        check("full word_count",  32'(word_count), 32'(exp_words));
        check("full in_ready",    32'(in_ready),   32'd0);
        check("full out_ham",     32'(out_ham),    32'(ref_encode(11'd1)));
        tick();
        check("stall out_ham",    32'(out_ham),    32'(ref_encode(11'd1)));
        check("stall word_count", 32'(word_count), 32'(exp_words));

        // Drain in order.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("drain%0d out_ham", i),   32'(out_ham),   32'(ref_encode(11'(i + 1))));
            tick();
            check($sformatf("drain%0d in_ready", i),  32'(in_ready),  32'd1);
        end
        check("drained out_valid", 32'(out_valid), 32'd0);
        check("drained out_ham",   32'(out_ham),   32'd0);

        // Streaming push/pop for 3*DEPTH words to wrap both pointers.
        for (int k = 1; k <= 3 * DEPTH; k++) begin
            in_valid = 1'b1;
            in_data  = 11'(k);
            tick();
            exp_words = exp_words + 1'b1;
            check($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stream%0d out_ham", k),   32'(out_ham),   32'(ref_encode(11'(k))));
        end
        in_valid = 1'b0;
        tick();
        check("stream end out_valid",  32'(out_valid),  32'd0);
        check("stream end word_count", 32'(word_count), 32'(exp_words));

        // Reset with a full FIFO and a word on the input.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 11'(i + 3);
            tick();
        end
        check("prefill out_valid", 32'(out_valid), 32'd1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 11'h123;
        inj_en   = 1'b1;
        inj_pos  = 4'd2;
        tick();
        check("reset out_valid",  32'(out_valid),  32'd0);
        check("reset in_ready",   32'(in_ready),   32'd1);
        check("reset out_ham",    32'(out_ham),    32'd0);
        check("reset word_count", 32'(word_count), 32'd0);
        check("reset inj_count",  32'(inj_count),  32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        inj_en   = 1'b0;
        tick();
        check("post-reset out_valid",  32'(out_valid),  32'd0);
        check("post-reset word_count", 32'(word_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ham_encode_stream.md
Name: ham_encode_stream

Overview:
- Streaming Hamming(15,11) encoder that sits directly upstream of the hamFix corrector.
- Accepts 11-bit data words on a valid/ready handshake, computes the 15-bit codeword and buffers it in a small FIFO, then presents it downstream on a second valid/ready handshake.
- Provides per-word single-bit error injection so that the corrector can be exercised in-system.
- Keeps counters of accepted words and injected errors.

Parameters:
- DEPTH, 2, number of codeword FIFO entries; must be a power of two, legal range 2..16.
- CNT_W, 16, width of the word and injection counters.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  [11:1]  data word to encode.
- inj_en  input  1  flip one codeword bit of the word accepted this cycle.
- inj_pos  input  [3:0]  codeword bit position to flip (1..15); 0 means no flip.
- out_valid  output  1  codeword available at FIFO head.
- out_ready  input  1  downstream consumes the head this cycle.
- out_ham  output  [15:1]  codeword at FIFO head.
- word_count  output  [CNT_W-1:0]  words accepted since reset.
- inj_count  output  [CNT_W-1:0]  errors actually injected since reset.

Behaviour:
- Reset (synchronous, active-high, sampled on the clock edge):
  - FIFO empty; read/write pointers 0.
  - out_valid=0, in_ready=1, out_ham=0, word_count=0, inj_count=0.
  - Reset overrides any simultaneous push or pop. An in-flight word is dropped.
- Parity equations:
  - p1 = d1^d2^d4^d5^d7^d9^d11
  - p2 = d1^d3^d4^d6^d7^d10^d11
  - p4 = d2^d3^d4^d8^d9^d10^d11
  - p8 = d5^d6^d7^d8^d9^d10^d11
- Codeword bit mapping, codeword[15:1] = {d11,d10,d9,d8,d7,d6,d5,p8,d4,d3,d2,p4,d1,p2,p1}:
  - bit1=p1, bit2=p2, bit3=d1, bit4=p4, bit5..7=d2..d4, bit8=p8, bit9..15=d5..d11.
- Accept (push): in_valid && in_ready on a clock edge.
  - The encoded word is written to the FIFO tail.
  - If inj_en && inj_pos != 0, bit inj_pos of the written word is inverted and inj_count increments.
  - inj_pos is ignored when inj_en=0.
- Pop: out_valid && out_ready on a clock edge advances the head.
- in_ready = (occupancy < DEPTH). It depends only on registered state, never combinationally on out_ready.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- out_valid = (occupancy != 0). out_ham is the head entry and is held stable while out_valid && !out_ready.
- out_ham returns 0 when the FIFO is empty.
- Latency: a word accepted at edge N is visible on out_ham/out_valid after edge N when the FIFO was empty; there is no combinational in-to-out path.
- Simultaneous push and pop when not full and not empty: occupancy unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter of width log2(DEPTH)+1.
- word_count and inj_count wrap from 2^CNT_W-1 to 0 with no saturation and no flag.
- Inputs with in_valid=0 have no effect, whatever values are on in_data, inj_en and inj_pos.

Test Plan:
1. Reset, then push in_data=11'h001 with out_ready=1 → next cycle out_valid=1, out_ham=15'h0007, word_count=1, inj_count=0.
2. Push 11'h000 and then 11'h7FF back-to-back with out_ready=1 → out_ham=15'h0000 then 15'h7FFF on consecutive cycles; word_count=2.
3. Push 11'h000 with inj_en=1, inj_pos=5 → out_ham=15'h0010, inj_count=1. Push again with inj_en=1, inj_pos=0 → out_ham=15'h0000, inj_count stays 1.
4. Hold out_ready=0 and push DEPTH words → in_ready=0 after the DEPTH-th accept. A further in_valid is not accepted and word_count stays at DEPTH. Raise out_ready → words drain in order with out_ham stable while stalled, and in_ready rises after the first pop.
5. Push/pop every cycle for 3*DEPTH words, encoding data 1..3*DEPTH → output order and values match the encoding of each input, demonstrating pointer wrap-around.
6. Assert reset with FIFO holding 2 words and in_valid=1 → next cycle out_valid=0, in_ready=1, both counts 0, and the word presented during the reset cycle is not stored.
